// File: rtl/alu_cmd_ctrl.sv
// Command sequencer in front of the ALU: collects a header/opA/opB byte frame,
// fires the ALU once, waits for the result with a timeout and streams it back LS byte first.
module alu_cmd_ctrl #(
   parameter int unsigned DATA_W  = 8,
   parameter logic [3:0]  HDR     = 4'hA,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [3:0]            ALU_FUN,
   output logic                  alu_en,
   output logic [DATA_W-1:0]     op_a,
   output logic [DATA_W-1:0]     op_b,
   input  logic [2*DATA_W-1:0]   alu_out,
   input  logic                  alu_out_valid,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  frame_err,
   output logic                  rx_ovr
);

   localparam int unsigned RES_W = 2 * DATA_W;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_A,
      S_GET_B,
      S_EXEC,
      S_WAIT_RES,
      S_SEND_LO,
      S_SEND_HI
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          fun_q, fun_d;
   logic [DATA_W-1:0]   op_a_q, op_a_d;
   logic [DATA_W-1:0]   op_b_q, op_b_d;
   logic [RES_W-1:0]    res_q, res_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    cnt_inc;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic                alu_en_q, alu_en_d;
   logic                busy_q, busy_d;
   logic                frame_err_q, frame_err_d;
   logic                rx_ovr_q, rx_ovr_d;

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      fun_d       = fun_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      res_d       = res_q;
      cnt_d       = cnt_q;
      cnt_inc     = cnt_q + CNT_W'(1);
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      frame_err_d = 1'b0;
      rx_ovr_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               if (rx_data[7:4] == HDR) begin
                  fun_d   = rx_data[3:0];
                  state_d = S_GET_A;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         S_GET_A: begin
            if (rx_valid) begin
               op_a_d  = DATA_W'(rx_data);
               state_d = S_GET_B;
            end
         end
         S_GET_B: begin
            if (rx_valid) begin
               op_b_d  = DATA_W'(rx_data);
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            cnt_d   = '0;
            state_d = S_WAIT_RES;
         end
         S_WAIT_RES: begin
            // A result arriving on the timeout cycle still wins
            if (alu_out_valid) begin
               res_d      = alu_out;
               tx_data_d  = 8'(alu_out);
               tx_valid_d = 1'b1;
               state_d    = S_SEND_LO;
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               cnt_d       = cnt_inc;
               frame_err_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_SEND_LO: begin
            if (tx_ready) begin
               tx_data_d = 8'(res_q >> DATA_W);
               state_d   = S_SEND_HI;
            end
         end
         S_SEND_HI: begin
            if (tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Bytes arriving while a frame is in flight are dropped
      rx_ovr_d = rx_valid && (state_q inside {S_EXEC, S_WAIT_RES, S_SEND_LO, S_SEND_HI});
      alu_en_d = (state_d == S_EXEC);
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         fun_q       <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         alu_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         rx_ovr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         fun_q       <= fun_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         alu_en_q    <= alu_en_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
         rx_ovr_q    <= rx_ovr_d;
      end
   end

   assign ALU_FUN   = fun_q;
   assign op_a      = op_a_q;
   assign op_b      = op_b_q;
   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign alu_en    = alu_en_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;
   assign rx_ovr    = rx_ovr_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl: directed scenarios followed by random frames,
// with an ALU stand-in whose results come from a plain arithmetic model.
module tb_alu_cmd_ctrl;

   localparam int unsigned TO = 15;

   typedef struct packed {
      logic [3:0] fun;
      logic [7:0] a;
      logic [7:0] b;
   } cmd_t;

   logic        CLK;
   logic        RST;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [3:0]  ALU_FUN;
   logic        alu_en;
   logic [7:0]  op_a;
   logic [7:0]  op_b;
   logic [15:0] alu_out;
   logic        alu_out_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        frame_err;
   logic        rx_ovr;

   alu_cmd_ctrl #(.DATA_W(8), .HDR(4'hA), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
      .ALU_FUN(ALU_FUN), .alu_en(alu_en), .op_a(op_a), .op_b(op_b),
      .alu_out(alu_out), .alu_out_valid(alu_out_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .frame_err(frame_err), .rx_ovr(rx_ovr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_ferr = 0;
   int   act_ferr = 0;
   int   exp_ovr  = 0;
   int   act_ovr  = 0;
   int   rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
   cmd_t       cmd_q[$];
   logic [7:0] tx_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stand-in ALU behaviour: unit in fun[3:2], operation in fun[1:0]
   function automatic logic [15:0] alu_model(input logic [3:0] fun, input logic [7:0] a,
                                             input logic [7:0] b);
      int unsigned x, y;
      x = a;
      y = b;
      case (fun)
         4'h0: return 16'(x + y);
         4'h1: return 16'(x - y);
         4'h2: return 16'(x * y);
         4'h3: return {a, b};
         4'h4: return 16'(x & y);
         4'h5: return 16'(x | y);
         4'h6: return 16'(x ^ y);
         4'h7: return 16'(~(x & y));
         4'h8: return (x == y) ? 16'd1 : 16'd0;
         4'h9: return (x > y) ? 16'd2 : 16'd0;
         4'hA: return (x < y) ? 16'd3 : 16'd0;
         4'hB: return 16'(x + 1);
         4'hC: return 16'(x >> (y % 8));
         4'hD: return 16'(x << (y % 16));
         4'hE: return 16'(y << 8);
         default: return 16'(x * 3);
      endcase
   endfunction

   // Transmit-side ready generator, offset from the drive phase
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge CLK);
         #2;
         case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops expectations whenever the DUT presents an output
   always @(negedge CLK) begin
      if (!RST) begin
         if (alu_en) begin
            if (cmd_q.size() == 0) begin
               chk("alu_en_unexpected", 32'(alu_en), 32'd0);
            end else begin
               cmd_t c;
               c = cmd_q.pop_front();
               chk("alu_cmd", 32'({ALU_FUN, op_a, op_b}), 32'(c));
            end
         end
         if (tx_valid) begin
            if (tx_q.size() == 0) begin
               chk("tx_unexpected", 32'(tx_valid), 32'd0);
            end else begin
               chk("tx_byte", 32'(tx_data), 32'(tx_q[0]));
               if (tx_ready) void'(tx_q.pop_front());
            end
         end
         if (frame_err) act_ferr++;
         if (rx_ovr)    act_ovr++;
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         step();
         n++;
      end
      chk("return_idle", 32'(busy), 32'd0);
   endtask

   task automatic run_frame(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b,
                            input int delay, input bit respond, input bit ovr,
                            input int stall, input logic [15:0] res);
      int n;
      cmd_q.push_back('{fun: fun, a: a, b: b});
      if (respond) begin
         tx_q.push_back(res[7:0]);
         tx_q.push_back(res[15:8]);
      end
      send_byte({4'hA, fun});
      send_byte(a);
      send_byte(b);
      step();  // first cycle of the result wait
      if (respond) begin
         if (ovr) begin
            rx_data  = 8'h77;
            rx_valid = 1'b1;
            exp_ovr++;
         end
         repeat (delay) begin
            step();
            rx_valid = 1'b0;
         end
         alu_out       = res;
         alu_out_valid = 1'b1;
         step();
         alu_out_valid = 1'b0;
         rx_valid      = 1'b0;
         if (stall > 0) begin
            repeat (stall) begin
               chk("stall_tx_valid", 32'(tx_valid), 32'd1);
               step();
            end
            rdy_mode = 0;
         end
      end else begin
         n = 0;
         while (!frame_err && n < 100) begin
            step();
            n++;
         end
         exp_ferr++;
         chk("timeout_cycles", 32'(n), 32'(TO));
         chk("timeout_no_tx", 32'(tx_valid), 32'd0);
      end
      wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST           = 1'b1;
      rx_data       = 8'h00;
      rx_valid      = 1'b0;
      alu_out       = 16'h0;
      alu_out_valid = 1'b0;
      repeat (3) step();
      chk("rst_fun",  32'(ALU_FUN), 32'd0);
      chk("rst_a",    32'(op_a), 32'd0);
      chk("rst_b",    32'(op_b), 32'd0);
      chk("rst_tx",   32'({tx_data, tx_valid}), 32'd0);
      chk("rst_flags", 32'({alu_en, busy, frame_err, rx_ovr}), 32'd0);
      RST = 1'b0;
      step();

      // Basic add frame
      run_frame(4'h0, 8'h12, 8'h34, 3, 1'b1, 1'b0, 0, alu_model(4'h0, 8'h12, 8'h34));

      // Bad header, then a shift-unit frame
      send_byte(8'h5C);
      exp_ferr++;
      chk("badhdr_err",  32'(frame_err), 32'd1);
      chk("badhdr_busy", 32'({busy, alu_en}), 32'd0);
      step();
      run_frame(4'hD, 8'h0F, 8'h01, 1, 1'b1, 1'b0, 0, alu_model(4'hD, 8'h0F, 8'h01));

      // ALU silent -> timeout, then a normal frame
      run_frame(4'h6, 8'h55, 8'hAA, 0, 1'b0, 1'b0, 0, 16'h0);
      step();
      run_frame(4'h2, 8'h10, 8'h11, 2, 1'b1, 1'b0, 0, alu_model(4'h2, 8'h10, 8'h11));

      // Result on the last allowed cycle, and with zero latency
      run_frame(4'h1, 8'h05, 8'h09, TO - 1, 1'b1, 1'b0, 0, alu_model(4'h1, 8'h05, 8'h09));
      run_frame(4'h3, 8'hC3, 8'h3C, 0, 1'b1, 1'b0, 0, alu_model(4'h3, 8'hC3, 8'h3C));

      // Transmitter stalled for 10 cycles
      rdy_mode = 2;
      step();
      run_frame(4'hE, 8'h01, 8'h02, 2, 1'b1, 1'b0, 10, 16'hBEEF);

      // Overrun byte during result wait
      run_frame(4'h5, 8'h21, 8'h42, 4, 1'b1, 1'b1, 0, alu_model(4'h5, 8'h21, 8'h42));
      step();

      // Reset mid-frame
      send_byte(8'hA4);
      send_byte(8'h09);
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("midrst_fun", 32'(ALU_FUN), 32'd0);
      chk("midrst_ops", 32'({op_a, op_b}), 32'd0);
      chk("midrst_flags", 32'({alu_en, busy, frame_err, rx_ovr, tx_valid}), 32'd0);
      send_byte(8'h22);
      exp_ferr++;
      chk("midrst_badhdr", 32'(frame_err), 32'd1);
      step();
      run_frame(4'h4, 8'h09, 8'h03, 2, 1'b1, 1'b0, 0, alu_model(4'h4, 8'h09, 8'h03));

      // Randomized traffic with random transmitter back-pressure
      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         logic [3:0] f;
         logic [7:0] a, b;
         int         kind;
         f    = 4'($urandom_range(0, 15));
         a    = 8'($urandom_range(0, 255));
         b    = 8'($urandom_range(0, 255));
         kind = int'($urandom_range(0, 9));
         if (kind == 0) begin
            logic [3:0] h;
            h = 4'($urandom_range(0, 14));
            if (h == 4'hA) h = 4'hF;
            send_byte({h, f});
            exp_ferr++;
            step();
         end else if (kind == 1) begin
            run_frame(f, a, b, 0, 1'b0, 1'b0, 0, 16'h0);
         end else begin
            run_frame(f, a, b, int'($urandom_range(0, TO - 1)), 1'b1,
                      1'($urandom_range(0, 1)), 0, alu_model(f, a, b));
         end
         repeat ($urandom_range(0, 2)) step();
      end

      rdy_mode = 0;
      repeat (5) step();
      chk("frame_err_count", 32'(act_ferr), 32'(exp_ferr));
      chk("rx_ovr_count",    32'(act_ovr), 32'(exp_ovr));
      chk("cmd_q_drained",   32'(cmd_q.size()), 32'd0);
      chk("tx_q_drained",    32'(tx_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
